// File: rtl/vga_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vga_ctrl_pkg
// Shared constants and types for the VGA control path: screen geometry,
// scene-data field widths, update-slot identifiers and a small helper used
// by the round-robin arbiter to step through slots cyclically.
// -----------------------------------------------------------------------------
package vga_ctrl_pkg;

    localparam int unsigned H_PIXEL   = 640;
    localparam int unsigned V_PIXEL   = 480;

    localparam int unsigned DEST_W    = 8;
    localparam int unsigned STATE_W   = 2;
    localparam int unsigned PEOPLE_W  = 26;

    localparam int unsigned NUM_SLOTS = 3;
    localparam int unsigned IDX_DEST   = 0;
    localparam int unsigned IDX_STATE  = 1;
    localparam int unsigned IDX_PEOPLE = 2;

    typedef enum logic [1:0] {
        SLOT_DEST   = 2'd0,
        SLOT_STATE  = 2'd1,
        SLOT_PEOPLE = 2'd2
    } slot_id_t;

    // (base + off) mod NUM_SLOTS; base is assumed already in range.
    function automatic logic [1:0] slot_add(input logic [1:0] base, input int unsigned off);
        int unsigned sum;
        sum = (int'(base) + off) % NUM_SLOTS;
        return sum[1:0];
    endfunction

endpackage

// File: rtl/vga_update_scheduler_rr_arbiter3.sv
// -----------------------------------------------------------------------------
// rr_arbiter3
// Purely combinational three-way round-robin arbiter. The pointer register
// lives in the parent.
//   req[2:0]      requests, bit index = slot id
//   ptr[1:0]      slot with highest priority this cycle
//   block         forces no grant (pointer then holds)
//   grant[2:0]    one-hot grant, all zero when nothing granted
//   next_ptr[1:0] slot after the granted one, or ptr when nothing granted
// -----------------------------------------------------------------------------
module rr_arbiter3
    import vga_ctrl_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    input  logic       block,
    output logic [2:0] grant,
    output logic [1:0] next_ptr
);

    logic [1:0] start;
    logic [1:0] cand;
    logic       found;

    // An out-of-range pointer (3) is treated as slot 0 so the arbiter
    // self-recovers rather than starving everyone.
    assign start = (ptr == 2'd3) ? 2'd0 : ptr;

    always_comb begin
        grant    = '0;
        next_ptr = start;
        found    = 1'b0;
        cand     = start;
        if (!block) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                cand = slot_add(start, i);
                if (!found && req[cand]) begin
                    grant[cand] = 1'b1;
                    next_ptr    = slot_add(cand, 1);
                    found       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_update_scheduler.sv
// -----------------------------------------------------------------------------
// vga_update_scheduler
// Collects scene-data updates from three producers into pending registers and
// commits them all together at the start of vertical blanking, so pixel_gen
// never sees a value change mid-frame.
//   pixel_clk, reset               clock, synchronous active-high reset
//   vert_count[9:0]                current line from the VGA timing counter
//   dest_req/dest_data[7:0]        destination update handshake
//   state_req/state_data[1:0]      sim_state update handshake
//   people_req/people_data_in[25:0] people_data update handshake
//   dest_ack/state_ack/people_ack  grants; data captured on the acked edge
//   destination/sim_state/people_data  committed display values
//   commit                         one-cycle pulse when committed values change
//   frame_count                    number of commits, wrapping
//   overwrite_flags[2:0]           sticky {people, state, dest} overwrite flags
// -----------------------------------------------------------------------------
module vga_update_scheduler
    import vga_ctrl_pkg::*;
#(
    parameter int unsigned VBLANK_LINE = 480,
    parameter int unsigned FRAME_CNT_W = 8
) (
    input  logic                   pixel_clk,
    input  logic                   reset,
    input  logic [9:0]             vert_count,
    input  logic                   dest_req,
    input  logic [DEST_W-1:0]      dest_data,
    input  logic                   state_req,
    input  logic [STATE_W-1:0]     state_data,
    input  logic                   people_req,
    input  logic [PEOPLE_W-1:0]    people_data_in,
    output logic                   dest_ack,
    output logic                   state_ack,
    output logic                   people_ack,
    output logic [DEST_W-1:0]      destination,
    output logic [STATE_W-1:0]     sim_state,
    output logic [PEOPLE_W-1:0]    people_data,
    output logic                   commit,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [2:0]             overwrite_flags
);

    logic                vblank;
    logic                vblank_d;
    logic                commit_now;
    logic [1:0]          rr_ptr;
    logic [1:0]          next_ptr;
    logic [2:0]          req;
    logic [2:0]          grant;
    logic [2:0]          pending_valid;
    logic [DEST_W-1:0]   pend_dest;
    logic [STATE_W-1:0]  pend_state;
    logic [PEOPLE_W-1:0] pend_people;

    assign vblank     = (vert_count >= 10'(VBLANK_LINE));
    assign commit_now = vblank & ~vblank_d;

    assign req = {people_req, state_req, dest_req};

    // Grants are blocked on the commit cycle so an accept never races the
    // pending->output copy; a blocked requester simply waits one cycle.
    rr_arbiter3 u_arb (
        .req      (req),
        .ptr      (rr_ptr),
        .block    (commit_now),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    assign dest_ack   = grant[IDX_DEST];
    assign state_ack  = grant[IDX_STATE];
    assign people_ack = grant[IDX_PEOPLE];

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            // Starting "in blank" suppresses a spurious commit when reset is
            // released during vertical blanking.
            vblank_d        <= 1'b1;
            rr_ptr          <= '0;
            pending_valid   <= '0;
            destination     <= '0;
            sim_state       <= '0;
            people_data     <= '0;
            commit          <= 1'b0;
            frame_count     <= '0;
            overwrite_flags <= '0;
        end else begin
            vblank_d <= vblank;
            rr_ptr   <= next_ptr;
            commit   <= commit_now;

            if (commit_now) begin
                if (pending_valid[IDX_DEST])   destination <= pend_dest;
                if (pending_valid[IDX_STATE])  sim_state   <= pend_state;
                if (pending_valid[IDX_PEOPLE]) people_data <= pend_people;
                pending_valid <= '0;
                frame_count   <= frame_count + FRAME_CNT_W'(1);
            end else begin
                for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                    if (grant[i]) begin
                        pending_valid[i] <= 1'b1;
                        if (pending_valid[i]) overwrite_flags[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Pending data needs no reset: it is only ever observed through
    // pending_valid, which is cleared by reset.
    always_ff @(posedge pixel_clk) begin
        if (grant[IDX_DEST])   pend_dest   <= dest_data;
        if (grant[IDX_STATE])  pend_state  <= state_data;
        if (grant[IDX_PEOPLE]) pend_people <= people_data_in;
    end

endmodule

// File: doc/vga_update_scheduler.md
# vga_update_scheduler

Sequences all scene-data updates into the VGA pixel generator so the picture never tears mid-frame. Three producers (elevator destination, simulation state, people data) each hand off new values through a req/ack port. A round-robin arbiter grants one port per cycle into per-slot pending registers. All pending slots are committed atomically to the display-facing registers on the first `pixel_clk` of vertical blanking. Sits between the elevator core and `pixel_gen`, in the `pixel_clk` domain.

## Interface
Parameters:
- `VBLANK_LINE`, 480: first vertical line of blanking (vert_pixel).
- `FRAME_CNT_W`, 8: width of the frame counter.

Ports:
- `pixel_clk`  in  1  pixel clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `vert_count`  in  10  current line from the VGA timing counter.
- `dest_req` / `dest_data`  in  1 / 8  destination update request / value.
- `state_req` / `state_data`  in  1 / 2  sim_state update request / value.
- `people_req` / `people_data_in`  in  1 / 26  people_data update request / value.
- `dest_ack`, `state_ack`, `people_ack`  out  1 each  grant; data is captured at the clock edge where ack=1.
- `destination`  out  8  committed value to `pixel_gen`.
- `sim_state`  out  2  committed value.
- `people_data`  out  26  committed value.
- `commit`  out  1  one-cycle pulse on the cycle the committed outputs change.
- `frame_count`  out  `FRAME_CNT_W`  number of commits, modulo 2^W.
- `overwrite_flags`  out  3  sticky per slot {people, state, dest}; set when an accepted value replaces an uncommitted one.

## Operation
- `vblank = (vert_count >= VBLANK_LINE)`; `vblank_d` is its registered copy.
- `commit_now = vblank & ~vblank_d`.
- Per slot: `pending_data` and `pending_valid`.
- Arbitration:
  - `rr_ptr` ∈ {0 = dest, 1 = state, 2 = people}.
  - Grant goes to the first requesting slot at or after `rr_ptr`, cyclically.
  - After a grant, `rr_ptr = (granted + 1) mod 3`; with no grant, `rr_ptr` holds.
  - At most one ack per cycle.
  - Acks are combinational from `req` and registered state, and are gated to 0 when `commit_now` = 1.
- Accept (granted slot):
  - `pending_data <= data`, `pending_valid <= 1`.
  - If `pending_valid` was already 1, set that slot's `overwrite_flags` bit (latest value wins).
- Commit (cycle after `commit_now` samples 1):
  - Each slot with `pending_valid` = 1 copies `pending_data` to its output and clears `pending_valid`.
  - Slots with `pending_valid` = 0 keep their output.
  - `commit` pulses, and `frame_count` increments and wraps to 0 after its maximum.
  - `commit` pulses every frame, even with nothing pending.
- A requester holds `req` and data stable until it sees ack; a request held across `commit_now` waits one cycle.
- Reset:
  - `destination`, `sim_state`, `people_data`, `frame_count`, `overwrite_flags`, `commit`, `rr_ptr`, and all `pending_valid` clear to 0.
  - `vblank_d` resets to 1, so a reset released during blanking produces no commit until the next frame.
  - Reset mid-frame discards all pending data.

## Timing
- Accept latency: 0 cycles; ack is seen in the same cycle as `req`, and data is captured at that edge.
- Commit latency: outputs update at the edge after the first cycle with `vert_count == VBLANK_LINE`; they are stable for the whole next active frame.
- Worst-case grant wait with all three requesting: 2 cycles, plus 1 if a commit intervenes.
- Outputs, `commit`, `frame_count` and `overwrite_flags` are all registered; there is no combinational path from inputs to them.

## Structure
- Package `vga_ctrl_pkg` holds:
  - localparams: `H_PIXEL = 640`, `V_PIXEL = 480`, the slot indices, and `DEST_W = 8`, `STATE_W = 2`, `PEOPLE_W = 26`;
  - a typedef enum for the slot id.
- Sub-module `rr_arbiter3`:
  - inputs `req[2:0]`, `ptr[1:0]`, `block`;
  - outputs one-hot `grant[2:0]` and `next_ptr`;
  - purely combinational; `rr_ptr` is stored in the parent.
- Top-level `vga_update_scheduler` holds the pending/valid registers, edge detect, committed registers and counters.

## Test plan
- Reset high 3 cycles, `vert_count` = 100 → all outputs 0, no acks without req.
- `dest_req`, `dest_data = 8'h05` at line 100 → `dest_ack` same cycle; `destination` stays 0 until line 480 reaches the register, then becomes 8'h05 with `commit` = 1 and `frame_count` = 1.
- All three reqs asserted continuously from `rr_ptr` = 0 → acks in order dest, state, people, dest… one per cycle.
- Two `state_req` accepts (`2'b01`, then `2'b10`) before blanking → `sim_state` = `2'b10` after commit, `overwrite_flags[1]` = 1 and stays 1.
- `people_req` asserted on the exact `commit_now` cycle → no ack that cycle, ack next cycle; value appears at the following frame's commit.
- Reset asserted while `vert_count` = 490 with pending data, then released → no commit during this blank, pending data lost, next commit at line 480 leaves outputs 0 and sets `frame_count` = 1.
